// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - diagonal operand skew stage and job sequencer feeding an N1xN2 systolic array.
// Accepts one A/B beat per cycle while streaming, then drains the skew pipes and pulses done.
module systolic_feeder #(
    parameter int D_W = 8,
    parameter int N1  = 4,
    parameter int N2  = 8,
    parameter int M   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [N1*D_W-1:0]   in_A,
    input  logic [N2*D_W-1:0]   in_B,
    output logic [N1*D_W-1:0]   a_out,
    output logic [N1-1:0]       a_valid,
    output logic [N2*D_W-1:0]   b_out,
    output logic [N2-1:0]       b_valid,
    output logic                enable_row_count,
    output logic                busy,
    output logic                done
);

    localparam int PATCHES = M / N2;
    localparam int TOTAL   = M * (M / N1) * (M / N2);
    localparam int DRAIN   = (N1 > N2) ? N1 : N2;
    localparam int BEAT_W  = $clog2(TOTAL + 1);
    localparam int DRN_W   = $clog2(DRAIN + 1);
    localparam int PIX_W   = $clog2(M + 1);
    localparam int PAT_W   = $clog2(PATCHES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t              r_state;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [PIX_W-1:0]    r_pixel;
    logic [PAT_W-1:0]    r_patch;
    logic [DRN_W-1:0]    r_drain_cnt;
    logic                r_erc;
    logic                r_done;

    logic w_accept;
    logic w_last_beat;

    assign w_accept    = in_valid && (r_state == S_STREAM);
    assign w_last_beat = w_accept && (r_beat_cnt == BEAT_W'(TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_beat_cnt  <= '0;
            r_pixel     <= '0;
            r_patch     <= '0;
            r_drain_cnt <= '0;
            r_erc       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Strobe one beat early so control sees it as the slice's last pixel arrives.
            r_erc  <= w_accept && (r_pixel == PIX_W'(M - 2)) && (r_patch == PAT_W'(PATCHES - 1));
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_STREAM;
                        r_beat_cnt <= '0;
                        r_pixel    <= '0;
                        r_patch    <= '0;
                    end
                end
                S_STREAM: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        if (r_pixel == PIX_W'(M - 1)) begin
                            r_pixel <= '0;
                            r_patch <= (r_patch == PAT_W'(PATCHES - 1)) ? '0 : r_patch + PAT_W'(1);
                        end else begin
                            r_pixel <= r_pixel + PIX_W'(1);
                        end
                        if (w_last_beat) begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DRN_W'(DRAIN - 1)) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DRN_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Lane i is an (i+1)-deep shift chain; idle slots enter as zero data with zero valid.
    for (genvar i = 0; i < N1; i++) begin : g_a_lane
        logic [D_W-1:0] r_d [0:i];
        logic [i:0]     r_v;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) begin
                    r_d[k] <= '0;
                end
                r_v <= '0;
            end else begin
                r_d[0] <= w_accept ? in_A[i*D_W +: D_W] : '0;
                r_v[0] <= w_accept;
                for (int k = 1; k <= i; k++) begin
                    r_d[k] <= r_d[k-1];
                    r_v[k] <= r_v[k-1];
                end
            end
        end

        assign a_out[i*D_W +: D_W] = r_d[i];
        assign a_valid[i]          = r_v[i];
    end

    for (genvar j = 0; j < N2; j++) begin : g_b_lane
        logic [D_W-1:0] r_d [0:j];
        logic [j:0]     r_v;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= j; k++) begin
                    r_d[k] <= '0;
                end
                r_v <= '0;
            end else begin
                r_d[0] <= w_accept ? in_B[j*D_W +: D_W] : '0;
                r_v[0] <= w_accept;
                for (int k = 1; k <= j; k++) begin
                    r_d[k] <= r_d[k-1];
                    r_v[k] <= r_v[k-1];
                end
            end
        end

        assign b_out[j*D_W +: D_W] = r_d[j];
        assign b_valid[j]          = r_v[j];
    end

    assign enable_row_count = r_erc;
    assign busy             = (r_state != S_IDLE);
    assign done             = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard bench for systolic_feeder against a cycle-indexed job model.
module tb_systolic_feeder;

    localparam int D_W     = 8;
    localparam int N1      = 4;
    localparam int N2      = 8;
    localparam int M       = 16;
    localparam int PATCHES = M / N2;
    localparam int TOTAL   = M * (M / N1) * (M / N2);
    localparam int DRAIN   = (N1 > N2) ? N1 : N2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                in_valid = 1'b0;
    logic [N1*D_W-1:0]   in_A = '0;
    logic [N2*D_W-1:0]   in_B = '0;
    logic [N1*D_W-1:0]   a_out;
    logic [N1-1:0]       a_valid;
    logic [N2*D_W-1:0]   b_out;
    logic [N2-1:0]       b_valid;
    logic                enable_row_count;
    logic                busy;
    logic                done;

    systolic_feeder #(.D_W(D_W), .N1(N1), .N2(N2), .M(M)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .in_valid         (in_valid),
        .in_A             (in_A),
        .in_B             (in_B),
        .a_out            (a_out),
        .a_valid          (a_valid),
        .b_out            (b_out),
        .b_valid          (b_valid),
        .enable_row_count (enable_row_count),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             cyc;
        logic [D_W-1:0] data;
    } exp_t;

    exp_t qa[N1][$];
    exp_t qb[N2][$];
    int   q_erc[$];
    int   q_done[$];
    bit   exp_busy[int];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    // Job model: when streaming opens, beats accepted so far, last busy cycle of the drain.
    bit m_stream = 1'b0;
    int m_from   = 0;
    int m_acc    = 0;
    int m_end    = -100;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N1*D_W-1:0] rnd_a();
        return N1*D_W'($urandom());
    endfunction

    function automatic logic [N2*D_W-1:0] rnd_b();
        return N2*D_W'({$urandom(), $urandom()});
    endfunction

    task automatic purge(input int t);
        for (int i = 0; i < N1; i++)
            while (qa[i].size() > 0 && qa[i][qa[i].size()-1].cyc > t) void'(qa[i].pop_back());
        for (int j = 0; j < N2; j++)
            while (qb[j].size() > 0 && qb[j][qb[j].size()-1].cyc > t) void'(qb[j].pop_back());
        while (q_erc.size() > 0 && q_erc[q_erc.size()-1] > t) void'(q_erc.pop_back());
        while (q_done.size() > 0 && q_done[q_done.size()-1] > t) void'(q_done.pop_back());
    endtask

    task automatic step(input bit st, input bit v, input bit r,
                        input logic [N1*D_W-1:0] a, input logic [N2*D_W-1:0] b);
        int   t;
        exp_t e;
        @(posedge clk);
        #1;
        t        = cyc;
        start    = st;
        in_valid = v;
        rst      = r;
        in_A     = a;
        in_B     = b;
        exp_busy[t] = (m_stream && t >= m_from) || (t <= m_end);
        if (r) begin
            purge(t);
            m_stream = 1'b0;
            m_end    = -100;
        end else if (st && !exp_busy[t] && !m_stream) begin
            m_stream = 1'b1;
            m_from   = t + 1;
            m_acc    = 0;
        end else if (v && m_stream && t >= m_from) begin
            for (int i = 0; i < N1; i++) begin
                e.cyc  = t + 1 + i;
                e.data = a[i*D_W +: D_W];
                qa[i].push_back(e);
            end
            for (int j = 0; j < N2; j++) begin
                e.cyc  = t + 1 + j;
                e.data = b[j*D_W +: D_W];
                qb[j].push_back(e);
            end
            if ((m_acc % M) == M - 2 && ((m_acc / M) % PATCHES) == PATCHES - 1)
                q_erc.push_back(t + 1);
            m_acc++;
            if (m_acc == TOTAL) begin
                m_stream = 1'b0;
                m_end    = t + DRAIN;
                q_done.push_back(t + DRAIN + 1);
            end
        end
    endtask

    exp_t           me;
    logic [D_W-1:0] md;
    bit             mv;

    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < N1; i++) begin
                md = a_out[i*D_W +: D_W];
                mv = (qa[i].size() > 0 && qa[i][0].cyc == cyc);
                checks++;
                if (a_valid[i] !== mv) begin
                    errors++;
                    $display("FAIL a_valid[%0d] cyc %0d: got %0b want %0b", i, cyc, a_valid[i], mv);
                end
                checks++;
                if (mv) begin
                    me = qa[i].pop_front();
                    if (md !== me.data) begin
                        errors++;
                        $display("FAIL a_out[%0d] cyc %0d: got %0h want %0h", i, cyc, md, me.data);
                    end
                end else if (md !== '0) begin
                    errors++;
                    $display("FAIL a_out_hole[%0d] cyc %0d: got %0h want 0", i, cyc, md);
                end
            end
            for (int j = 0; j < N2; j++) begin
                md = b_out[j*D_W +: D_W];
                mv = (qb[j].size() > 0 && qb[j][0].cyc == cyc);
                checks++;
                if (b_valid[j] !== mv) begin
                    errors++;
                    $display("FAIL b_valid[%0d] cyc %0d: got %0b want %0b", j, cyc, b_valid[j], mv);
                end
                checks++;
                if (mv) begin
                    me = qb[j].pop_front();
                    if (md !== me.data) begin
                        errors++;
                        $display("FAIL b_out[%0d] cyc %0d: got %0h want %0h", j, cyc, md, me.data);
                    end
                end else if (md !== '0) begin
                    errors++;
                    $display("FAIL b_out_hole[%0d] cyc %0d: got %0h want 0", j, cyc, md);
                end
            end
            if (exp_busy.exists(cyc)) begin
                checks++;
                if (busy !== exp_busy[cyc]) begin
                    errors++;
                    $display("FAIL busy cyc %0d: got %0b want %0b", cyc, busy, exp_busy[cyc]);
                end
                exp_busy.delete(cyc);
            end
            mv = (q_erc.size() > 0 && q_erc[0] == cyc);
            if (mv) void'(q_erc.pop_front());
            checks++;
            if (enable_row_count !== mv) begin
                errors++;
                $display("FAIL enable_row_count cyc %0d: got %0b want %0b", cyc, enable_row_count, mv);
            end
            mv = (q_done.size() > 0 && q_done[0] == cyc);
            if (mv) void'(q_done.pop_front());
            checks++;
            if (done !== mv) begin
                errors++;
                $display("FAIL done cyc %0d: got %0b want %0b", cyc, done, mv);
            end
        end
    end

    initial begin
        logic [N1*D_W-1:0] pa;
        int                n;

        for (int k = 0; k < 3; k++) step(0, 0, 1, '0, '0);
        step(0, 0, 0, '0, '0);
        mon_on = 1'b1;
        for (int k = 0; k < 10; k++) step(0, 0, 0, '0, '0);

        // Job 1: continuous stream, patterned A, stray start/valid pulses ignored.
        step(1, 1, 0, rnd_a(), rnd_b());
        for (int k = 0; k < TOTAL; k++) begin
            for (int i = 0; i < N1; i++) pa[i*D_W +: D_W] = D_W'(16 * k + i);
            step(k == 50, 1, 0, pa, rnd_b());
        end
        for (int d = 0; d < 12; d++) step(d == 3, 1, 0, rnd_a(), rnd_b());

        // Job 2: one gap at slot 5.
        step(1, 0, 0, '0, '0);
        for (int s = 0; s <= TOTAL; s++) step(0, s != 5, 0, rnd_a(), rnd_b());
        for (int d = 0; d < 12; d++) step(0, 0, 0, '0, '0);

        // Job 3: aborted by reset at beat 40, then a full job.
        step(1, 0, 0, '0, '0);
        for (int s = 0; s < 40; s++) step(0, 1, 0, rnd_a(), rnd_b());
        step(0, 1, 1, rnd_a(), rnd_b());
        for (int s = 0; s < 3; s++) step(0, 0, 0, '0, '0);
        step(1, 1, 0, rnd_a(), rnd_b());
        for (int s = 0; s < TOTAL; s++) step(s == 10, 1, 0, rnd_a(), rnd_b());
        for (int d = 0; d < 12; d++) step(0, 0, 0, '0, '0);

        // Job 4: random in_valid density and random stray starts.
        step(1, 0, 0, '0, '0);
        n = 0;
        while (m_stream && n < 2000) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, 0, rnd_a(), rnd_b());
            n++;
        end
        checks++;
        if (m_stream) begin
            errors++;
            $display("FAIL job4_bound: got %0d beats want %0d", m_acc, TOTAL);
        end
        for (int d = 0; d < 12; d++) step(0, $urandom_range(0, 1) == 1, 0, rnd_a(), rnd_b());
        step(0, 0, 0, '0, '0);

        for (int i = 0; i < N1; i++) begin
            checks++;
            if (qa[i].size() != 0) begin
                errors++;
                $display("FAIL a_leftover[%0d]: got %0d pending want 0", i, qa[i].size());
            end
        end
        for (int j = 0; j < N2; j++) begin
            checks++;
            if (qb[j].size() != 0) begin
                errors++;
                $display("FAIL b_leftover[%0d]: got %0d pending want 0", j, qb[j].size());
            end
        end
        checks++;
        if (q_erc.size() != 0 || q_done.size() != 0) begin
            errors++;
            $display("FAIL strobe_leftover: got erc %0d done %0d pending want 0", q_erc.size(), q_done.size());
        end
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
